// File: rtl/reg_write_scoreboard.sv
// rtl/reg_write_scoreboard.sv - one-hot register write-enable decoder with pending-write scoreboard
module reg_write_scoreboard #(
    parameter int ADDR_W = 3,
    parameter int BYPASS = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                En,
    input  logic [ADDR_W-1:0]   W,
    input  logic                Iss,
    input  logic [ADDR_W-1:0]   IssAddr,
    input  logic                RdAV,
    input  logic                RdBV,
    input  logic [ADDR_W-1:0]   RdA,
    input  logic [ADDR_W-1:0]   RdB,
    output logic [2**ADDR_W-1:0] Y,
    output logic [2**ADDR_W-1:0] Busy,
    output logic [ADDR_W:0]     PendCnt,
    output logic                Stall,
    output logic                Orphan
);

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] mask;
    logic [NREG-1:0] eff;
    logic [NREG-1:0] clr;
    logic [NREG-1:0] set;
    logic [NREG-1:0] busy_next;
    logic [ADDR_W:0] cnt_next;
    logic            acc;

    // Hazard detection, issue acceptance and next scoreboard state
    always_comb begin
        mask = '0;
        if ((BYPASS != 0) && En) begin
            mask[W] = 1'b1;
        end
        eff   = Busy & ~mask;
        Stall = (RdAV & eff[RdA]) | (RdBV & eff[RdB]) | (Iss & eff[IssAddr]);
        acc   = Iss & ~Stall;

        clr = '0;
        if (En) begin
            clr[W] = 1'b1;
        end
        set = '0;
        if (acc) begin
            set[IssAddr] = 1'b1;
        end
        // Set is applied after clear so a same-register issue keeps the bit
        busy_next = (Busy & ~clr) | set;

        cnt_next = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    // Registered write enable, scoreboard, pending count and orphan pulse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Y       <= '0;
            Busy    <= '0;
            PendCnt <= '0;
            Orphan  <= 1'b0;
        end else begin
            Y       <= clr;
            Busy    <= busy_next;
            PendCnt <= cnt_next;
            Orphan  <= En & ~Busy[W];
        end
    end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// tb/tb_reg_write_scoreboard.sv - randomized and directed checks of reg_write_scoreboard against a reference model
module tb_reg_write_scoreboard;

    logic       Clock = 1'b0;
    logic       Reset, En, Iss, RdAV, RdBV;
    logic [2:0] W, IssAddr, RdA, RdB;

    logic [7:0] Y0, Busy0, Y1, Busy1;
    logic [3:0] PendCnt0, PendCnt1;
    logic       Stall0, Orphan0, Stall1, Orphan1;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: per-register pending flags for each bypass flavour
    bit         pend [2][8];
    bit [7:0]   exp_y [2];
    bit         exp_orphan [2];

    always #5 Clock = ~Clock;

    reg_write_scoreboard #(.ADDR_W(3), .BYPASS(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .En(En), .W(W), .Iss(Iss), .IssAddr(IssAddr),
        .RdAV(RdAV), .RdBV(RdBV), .RdA(RdA), .RdB(RdB),
        .Y(Y0), .Busy(Busy0), .PendCnt(PendCnt0), .Stall(Stall0), .Orphan(Orphan0)
    );

    reg_write_scoreboard #(.ADDR_W(3), .BYPASS(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .En(En), .W(W), .Iss(Iss), .IssAddr(IssAddr),
        .RdAV(RdAV), .RdBV(RdBV), .RdA(RdA), .RdB(RdB),
        .Y(Y1), .Busy(Busy1), .PendCnt(PendCnt1), .Stall(Stall1), .Orphan(Orphan1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hazard(input int b, input int r);
        return pend[b][r] && !(b == 1 && En && int'(W) == r);
    endfunction

    function automatic bit [7:0] busy_vec(input int b);
        bit [7:0] v = '0;
        for (int r = 0; r < 8; r++) v[r] = pend[b][r];
        return v;
    endfunction

    function automatic int pending(input int b);
        int n = 0;
        for (int r = 0; r < 8; r++) n += pend[b][r];
        return n;
    endfunction

    // Apply one cycle of inputs (called just after a falling edge)
    task automatic cyc(input bit rst, input bit en, input int w, input bit iss, input int ia,
                       input bit rav, input int ra, input bit rbv, input int rb);
        bit stl [2];
        Reset = rst; En = en; W = 3'(w); Iss = iss; IssAddr = 3'(ia);
        RdAV = rav; RdA = 3'(ra); RdBV = rbv; RdB = 3'(rb);
        #1;
        for (int b = 0; b < 2; b++) begin
            stl[b] = (rav && hazard(b, ra)) || (rbv && hazard(b, rb)) || (iss && hazard(b, ia));
        end
        check("stall_nobyp", {31'd0, Stall0}, {31'd0, stl[0]});
        check("stall_byp",   {31'd0, Stall1}, {31'd0, stl[1]});
        for (int b = 0; b < 2; b++) begin
            if (rst) begin
                for (int r = 0; r < 8; r++) pend[b][r] = 0;
                exp_y[b] = '0;
                exp_orphan[b] = 0;
            end else begin
                exp_y[b] = en ? (8'd1 << w) : 8'd0;
                exp_orphan[b] = en && !pend[b][w];
                if (en) pend[b][w] = 0;
                if (iss && !stl[b]) pend[b][ia] = 1;
            end
        end
        @(posedge Clock);
        #1;
        check("y_nobyp",      {24'd0, Y0},       {24'd0, exp_y[0]});
        check("busy_nobyp",   {24'd0, Busy0},    {24'd0, busy_vec(0)});
        check("cnt_nobyp",    {28'd0, PendCnt0}, 32'(pending(0)));
        check("orphan_nobyp", {31'd0, Orphan0},  {31'd0, exp_orphan[0]});
        check("y_byp",        {24'd0, Y1},       {24'd0, exp_y[1]});
        check("busy_byp",     {24'd0, Busy1},    {24'd0, busy_vec(1)});
        check("cnt_byp",      {28'd0, PendCnt1}, 32'(pending(1)));
        check("orphan_byp",   {31'd0, Orphan1},  {31'd0, exp_orphan[1]});
        check("y_onehot",     {31'd0, ($countones(Y0) <= 1) && ($countones(Y1) <= 1)}, 32'd1);
        @(negedge Clock);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset = 1; En = 0; W = 0; Iss = 0; IssAddr = 0; RdAV = 0; RdA = 0; RdBV = 0; RdB = 0;
        for (int b = 0; b < 2; b++) for (int r = 0; r < 8; r++) pend[b][r] = 0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("reset_y",    {24'd0, Y0},       32'd0);
        check("reset_busy", {24'd0, Busy0},    32'd0);
        check("reset_cnt",  {28'd0, PendCnt0}, 32'd0);
        check("reset_orph", {31'd0, Orphan0},  32'd0);

        // Orphan writeback right after reset
        cyc(0, 1, 5, 0, 0, 0, 0, 0, 0);
        check("wb5_y",      {24'd0, Y0},      32'h20);
        check("wb5_orphan", {31'd0, Orphan0}, 32'd1);
        idle();
        check("wb5_y_off",  {24'd0, Y0},      32'h0);

        // Issue, RAW stall, writeback
        cyc(0, 0, 0, 1, 2, 0, 0, 0, 0);
        check("iss2_busy", {24'd0, Busy0},    32'h04);
        check("iss2_cnt",  {28'd0, PendCnt0}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 2, 0, 0);
        cyc(0, 1, 2, 0, 0, 0, 0, 0, 0);
        check("wb2_busy",   {24'd0, Busy0},   32'h00);
        check("wb2_y",      {24'd0, Y0},      32'h04);
        check("wb2_orphan", {31'd0, Orphan0}, 32'd0);

        // Fill the scoreboard, then a dropped 9th issue
        for (int r = 0; r < 8; r++) begin
            cyc(0, 0, 0, 1, r, 0, 0, 0, 0);
            check("fill_cnt", {28'd0, PendCnt0}, 32'(r + 1));
        end
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("full_busy", {24'd0, Busy0},    32'hFF);
        check("full_cnt",  {28'd0, PendCnt0}, 32'h8);

        // Drain, then same-register writeback and issue
        for (int r = 0; r < 8; r++) cyc(0, 1, r, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 4, 0, 0, 0, 0);
        cyc(0, 1, 4, 1, 4, 0, 0, 0, 0);
        check("same_nobyp_busy", {24'd0, Busy0},    32'h00);
        check("same_byp_busy",   {24'd0, Busy1},    32'h10);
        check("same_byp_cnt",    {28'd0, PendCnt1}, 32'd1);
        check("same_byp_y",      {24'd0, Y1},       32'h10);

        // Reset overrides a simultaneous writeback and issue
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 0, 0, 0, 0);
        check("pre_rst_busy", {24'd0, Busy0}, 32'h09);
        cyc(1, 1, 0, 1, 5, 0, 0, 0, 0);
        check("rst_y",    {24'd0, Y0},       32'd0);
        check("rst_busy", {24'd0, Busy0},    32'd0);
        check("rst_cnt",  {28'd0, PendCnt0}, 32'd0);
        check("rst_orph", {31'd0, Orphan0},  32'd0);

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                ($urandom_range(0, 1) == 0), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_write_scoreboard.md
# reg_write_scoreboard

Parametrised successor to the register write-enable decoder in the multicycle processor. It sits between the control FSM and the register bank, and has two jobs. First, it turns a writeback request (address plus enable) into a registered one-hot write-enable vector for `NREG` registers. Second, it keeps a per-register pending-write scoreboard, so the control FSM can stall on RAW/WAW hazards. It also reports the pending count and flags writebacks to registers that had no pending write.

## Interface
- `ADDR_W`, 3, register address width; `NREG = 2**ADDR_W` (local, not overridable).
- `BYPASS`, 0, 1 = a writeback in the current cycle masks the hazard on that register; 0 = no masking.
- `Clock` input 1, single clock, all state updates on rising edge.
- `Reset` input 1, synchronous, active-high.
- `En` input 1, writeback request this cycle.
- `W` input ADDR_W, writeback destination address.
- `Iss` input 1, instruction issue request with destination register.
- `IssAddr` input ADDR_W, destination of issuing instruction.
- `RdAV`, `RdBV` input 1 each, source operand A/B valid.
- `RdA`, `RdB` input ADDR_W each, source operand addresses.
- `Y` output NREG, registered one-hot write enable to register bank.
- `Busy` output NREG, registered scoreboard, bit i = write to Reg i pending.
- `PendCnt` output ADDR_W+1, registered popcount of `Busy`.
- `Stall` output 1, combinational hazard indication for the current issue.
- `Orphan` output 1, registered one-cycle pulse: writeback to non-busy register.

## Operation
- Writeback decode: Y_next = En ? (1 << W) : 0. Exactly one bit of `Y` is set, or none. `Y` is never multi-hot.
- Hazard terms (combinational, from current `Busy` and inputs):
  - `mask` = (BYPASS && En) ? (1 << W) : 0; `eff` = Busy & ~mask.
  - Stall = (RdAV & eff[RdA]) | (RdBV & eff[RdB]) | (Iss & eff[IssAddr]).
- Issue acceptance: `acc` = Iss & ~Stall. `Iss` while `Stall`=1 is dropped. The FSM holds and re-presents it.
- Scoreboard update: `clr` = En ? (1 << W) : 0; `set` = acc ? (1 << IssAddr) : 0. Busy_next = (Busy & ~clr) | set. Set dominates clear on the same bit.
- PendCnt_next = popcount(Busy_next). It is registered, so it always equals popcount(`Busy`) and never lags.
- Orphan_next = En & ~Busy[W], evaluated against the current `Busy` before the update.
- `Stall` does not depend on `En` when BYPASS=0.

## Timing
- Reset (Reset=1 at rising edge): Y=0, Busy=0, PendCnt=0, Orphan=0. Stall reads 0 on the cycle after reset, because `Busy`=0.
- Reset overrides `En`/`Iss` in the same cycle. A pending write in flight when reset arrives is lost; no `Y` pulse follows.
- Latency: `En`/`W` at edge k gives `Y` at k+1, high one cycle. `Busy` clears and `Orphan` updates at the same edge.
- Accepted issue at edge k gives Busy[IssAddr]=1 from k+1.
- Simultaneous `En` and accepted `Iss` on the same address: `Y` pulses, `Busy` stays 1, PendCnt unchanged.
- Simultaneous `En` and accepted `Iss` on different addresses: one bit clears and one sets, so PendCnt is unchanged.
- BYPASS=1 with Iss to address W while En: no stall, issue accepted, bit stays 1.
- BYPASS=0, same case: Stall=1, issue dropped, bit clears.
- Full scoreboard: PendCnt = NREG (e.g. 8 = 4'b1000). The width ADDR_W+1 holds it without wrap.
- Back-to-back `En` to the same address: second writeback gives `Orphan`=1, and `Y` still pulses.

## Test plan
- Reset then En=1, W=3'b101 for one cycle: next cycle Y=8'b00100000, then Y=0. Orphan=1 one cycle. Busy=0, PendCnt=0.
- Iss=1, IssAddr=2: Busy=8'b00000100, PendCnt=1. Then RdAV=1, RdA=2: Stall=1. En, W=2: next cycle Busy=0, Y=8'b00000100, Orphan=0.
- Issue all 8 registers over 8 cycles: PendCnt counts 1..8, reaching 4'b1000. A 9th Iss to reg 0 gives Stall=1 and is dropped (Busy unchanged).
- Busy[4]=1, same cycle En with W=4 and Iss with IssAddr=4:
  - BYPASS=0: Stall=1, Busy[4]=0 next.
  - BYPASS=1: Stall=0, Busy[4]=1 next, PendCnt unchanged, Y=8'b00010000.
- Busy=8'b00001001, then Reset=1 with En=1, W=0 and Iss=1, IssAddr=5: next cycle Y=0, Busy=0, PendCnt=0, Orphan=0.
- Random 10k-cycle run vs. reference model: Y always zero or one-hot; PendCnt == popcount(Busy); no accepted Iss while Stall.
